// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP MAC sequencer.
// Contents:
//   seq_state_t      - sequencer FSM state encoding
//   OPM_*            - opmode field values used to steer the slice X/Z muxes
//   OPMODE_SUB_BIT   - opmode bit selecting Z - (X) instead of Z + X
//   DSP_MAC_LAT      - cycles from operand capture to P update in the slice
//   mac_opmode()     - builds the opmode word for one accumulate step
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    localparam logic [1:0] OPM_X_M    = 2'b01;
    localparam logic [1:0] OPM_Z_ZERO = 2'b00;
    localparam logic [1:0] OPM_Z_P    = 2'b10;
    localparam int         OPMODE_SUB_BIT = 7;

    // A1/B1 -> M -> P: operands captured at the end of cycle k reach P at the end of k+2.
    localparam int DSP_MAC_LAT = 3;

    // The first product of a frame loads P (Z=0); later products accumulate onto P.
    function automatic logic [7:0] mac_opmode(input logic sub, input logic first);
        logic [7:0] opm;
        opm                 = 8'h00;
        opm[1:0]            = OPM_X_M;
        opm[3:2]            = first ? OPM_Z_ZERO : OPM_Z_P;
        opm[OPMODE_SUB_BIT] = sub;
        return opm;
    endfunction

endpackage

// File: rtl/dsp_seq_shadow_pipe.sv
// Token shadow of the slice pipeline. Each accepted operand pair pushes a
// {valid, first} token; the token walks alongside the data through the slice
// M and P register stages and enables exactly the stage that holds it.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   flush         synchronous clear of all tokens (frame abort)
//   push          operand pair accepted this cycle
//   push_first    the accepted pair is the first of its frame
//   sub           frame subtract flag, copied into opmode
//   stage_m       a token is at the M stage (drives CEM/CEOPMODE)
//   stage_opmode  opmode for the token at the M stage, 0 when empty
//   stage_p       a token is at the P stage (drives CEP, counts a retire)
module dsp_seq_shadow_pipe
    import dsp_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       push_first,
    input  logic       sub,
    output logic       stage_m,
    output logic [7:0] stage_opmode,
    output logic       stage_p
);

    localparam int STAGES = DSP_MAC_LAT - 1;

    logic [STAGES-1:0] tok_valid;
    logic              tok_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_valid <= '0;
            tok_first <= 1'b0;
        end else if (flush) begin
            tok_valid <= '0;
            tok_first <= 1'b0;
        end else begin
            tok_valid <= {tok_valid[STAGES-2:0], push};
            // Only the M stage needs the first flag: opmode is registered there.
            tok_first <= push && push_first;
        end
    end

    assign stage_m      = tok_valid[0];
    assign stage_p      = tok_valid[STAGES-1];
    assign stage_opmode = tok_valid[0] ? mac_opmode(sub, tok_first) : 8'h00;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1-style slice (A1REG/B1REG/MREG/PREG/OPMODEREG = 1)
// through multiply-accumulate frames of programmable length.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; frame_len==0 flags len_err
// ST_RUN   | accepting operand pairs until frame_len transfers are done
// ST_DRAIN | waiting for the in-flight products to retire into P
// ST_HOLD  | presenting P on res_data until res_ready
//
// Ports:
//   clk, RST                 clock and asynchronous active-high reset
//   start, frame_len,
//   frame_sub, abort         frame control; busy/len_err status
//   in_valid/in_ready,
//   in_a, in_b               operand pair stream
//   res_valid/res_ready,
//   res_data                 accumulated result stream
//   dsp_*                    slice data, opmode, clock-enable and reset pins
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              frame_sub,
    input  logic              abort,
    output logic              busy,
    output logic              len_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [47:0]       res_data,
    output logic [DATA_W-1:0] dsp_A,
    output logic [DATA_W-1:0] dsp_B,
    output logic [7:0]        dsp_opmode,
    output logic              dsp_CEA,
    output logic              dsp_CEB,
    output logic              dsp_CEOPMODE,
    output logic              dsp_CEM,
    output logic              dsp_CEP,
    output logic              dsp_RSTM,
    output logic              dsp_RSTP,
    input  logic [47:0]       dsp_P
);

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    seq_state_t       state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] xfer_cnt;
    logic [LEN_W-1:0] retire_cnt;
    logic             sub_q;
    logic             len_err_q;
    logic             abort_q;

    logic             idle;
    logic             xfer;
    logic             first_xfer;
    logic             last_xfer;
    logic             retire;
    logic             last_retire;
    logic             abort_act;
    logic             start_ok;
    logic             stage_m;
    logic [7:0]       stage_opmode;

    assign idle       = (state == ST_IDLE);
    assign in_ready   = (state == ST_RUN);
    assign xfer       = in_valid && in_ready;
    assign first_xfer = xfer && (xfer_cnt == '0);
    // Compare against len-1 so the counters never need to exceed len,
    // which keeps frame_len = 2^LEN_W-1 free of wrap.
    assign last_xfer   = xfer && (xfer_cnt == len_q - CNT_ONE);
    assign last_retire = retire && (retire_cnt == len_q - CNT_ONE);
    assign abort_act   = abort && !idle;
    assign start_ok    = idle && start && (frame_len != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok)    state_nxt = ST_RUN;
            ST_RUN:   if (last_xfer)   state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_retire) state_nxt = ST_HOLD;
            ST_HOLD:  if (res_ready)   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
        if (abort_act) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            xfer_cnt   <= '0;
            retire_cnt <= '0;
            sub_q      <= 1'b0;
            len_err_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_err_q <= idle && start && (frame_len == '0);
            abort_q   <= abort_act;
            if (start_ok) begin
                len_q      <= frame_len;
                sub_q      <= frame_sub;
                xfer_cnt   <= '0;
                retire_cnt <= '0;
            end else if (abort_act) begin
                xfer_cnt   <= '0;
                retire_cnt <= '0;
            end else begin
                if (xfer)   xfer_cnt   <= xfer_cnt + CNT_ONE;
                if (retire) retire_cnt <= retire_cnt + CNT_ONE;
            end
        end
    end

    dsp_seq_shadow_pipe u_shadow (
        .clk          (clk),
        .rst          (RST),
        .flush        (abort_act),
        .push         (xfer),
        .push_first   (first_xfer),
        .sub          (sub_q),
        .stage_m      (stage_m),
        .stage_opmode (stage_opmode),
        .stage_p      (retire)
    );

    assign busy         = !idle;
    assign len_err      = len_err_q;
    assign res_valid    = (state == ST_HOLD);
    assign res_data     = res_valid ? dsp_P : 48'd0;

    assign dsp_A        = in_a;
    assign dsp_B        = in_b;
    assign dsp_CEA      = xfer;
    assign dsp_CEB      = xfer;
    assign dsp_CEM      = stage_m;
    assign dsp_CEOPMODE = stage_m;
    assign dsp_opmode   = stage_opmode;
    // The pipe is empty in HOLD, so CEP is already low and P holds the result.
    assign dsp_CEP      = retire;
    // Clearing M and P one cycle after abort discards any partial accumulation.
    assign dsp_RSTM     = abort_q;
    assign dsp_RSTP     = abort_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;

    localparam int LEN_W  = 6;
    localparam int DATA_W = 18;

    logic              clk;
    logic              RST;
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_sub;
    logic              abort;
    logic              busy;
    logic              len_err;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              res_valid;
    logic              res_ready;
    logic [47:0]       res_data;
    logic [DATA_W-1:0] dsp_A;
    logic [DATA_W-1:0] dsp_B;
    logic [7:0]        dsp_opmode;
    logic              dsp_CEA, dsp_CEB, dsp_CEOPMODE, dsp_CEM, dsp_CEP;
    logic              dsp_RSTM, dsp_RSTP;
    logic [47:0]       dsp_P;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic signed [DATA_W-1:0] opa [0:63];
    logic signed [DATA_W-1:0] opb [0:63];
    int                       gap [0:63];

    dsp_mac_sequencer #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .RST(RST), .start(start), .frame_len(frame_len),
        .frame_sub(frame_sub), .abort(abort), .busy(busy), .len_err(len_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_opmode(dsp_opmode),
        .dsp_CEA(dsp_CEA), .dsp_CEB(dsp_CEB), .dsp_CEOPMODE(dsp_CEOPMODE),
        .dsp_CEM(dsp_CEM), .dsp_CEP(dsp_CEP), .dsp_RSTM(dsp_RSTM),
        .dsp_RSTP(dsp_RSTP), .dsp_P(dsp_P)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slice: A1/B1 regs, M reg, registered opmode, P reg with X/Z muxes.
    logic signed [DATA_W-1:0]   sl_a1, sl_b1;
    logic signed [2*DATA_W-1:0] sl_m;
    logic [7:0]                 sl_opm;
    logic [47:0]                sl_p, sl_x, sl_z;

    assign sl_x  = (sl_opm[1:0] == 2'b01) ? {{(48-2*DATA_W){sl_m[2*DATA_W-1]}}, sl_m} : 48'd0;
    assign sl_z  = (sl_opm[3:2] == 2'b10) ? sl_p : 48'd0;
    assign dsp_P = sl_p;

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            sl_a1 <= '0; sl_b1 <= '0; sl_m <= '0; sl_opm <= '0; sl_p <= '0;
        end else begin
            if (dsp_CEA) sl_a1 <= dsp_A;
            if (dsp_CEB) sl_b1 <= dsp_B;
            if (dsp_RSTM) sl_m <= '0;
            else if (dsp_CEM) sl_m <= sl_a1 * sl_b1;
            if (dsp_CEOPMODE) sl_opm <= dsp_opmode;
            if (dsp_RSTP) sl_p <= '0;
            else if (dsp_CEP) sl_p <= sl_opm[7] ? (sl_z - sl_x) : (sl_z + sl_x);
        end
    end

    function automatic logic [47:0] ref_result(input int len, input bit sub);
        longint      acc;
        logic [47:0] r;
        acc = 0;
        for (int i = 0; i < len; i++) acc += longint'(opa[i]) * longint'(opb[i]);
        if (sub) acc = -acc;
        r = acc[47:0];
        return r;
    endfunction

    task automatic start_frame(input int len, input bit sub);
        @(negedge clk);
        start = 1'b1; frame_len = LEN_W'(len); frame_sub = sub;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at a negedge; leaves at the negedge after the last pair with in_valid=0.
    task automatic push_pairs(input int len, output int xc);
        xc = 0;
        for (int i = 0; i < len; i++) begin
            repeat (gap[i]) begin in_valid = 1'b0; @(negedge clk); end
            in_valid = 1'b1; in_a = opa[i]; in_b = opb[i]; xc = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int len, input bit sub, input int rdelay,
                             output logic [47:0] data, output int lat, output bit got);
        int xc;
        got = 1'b0; lat = -1; data = '0;
        start_frame(len, sub);
        push_pairs(len, xc);
        res_ready = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            #1;
            if (res_valid) begin got = 1'b1; lat = cyc - xc; data = res_data; end
            else @(negedge clk);
        end
        if (got) begin
            repeat (rdelay) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, res_valid, busy, len_err, dsp_CEA, dsp_CEB, dsp_CEOPMODE,
             dsp_CEM, dsp_CEP, dsp_RSTM, dsp_RSTP} !== 11'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0", {in_ready, res_valid, busy, len_err,
                     dsp_CEA, dsp_CEB, dsp_CEOPMODE, dsp_CEM, dsp_CEP, dsp_RSTM, dsp_RSTP});
        end
        checks++;
        if (dsp_opmode !== 8'h00 || res_data !== 48'd0) begin
            failures++;
            $display("FAIL reset_data opmode=%h res_data=%h want=0", dsp_opmode, res_data);
        end
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b in_ready=%b want=0", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] d; int lat; bit got;
        for (int i = 0; i < 4; i++) begin
            opa[i] = DATA_W'(2*i+1); opb[i] = DATA_W'(2*i+2); gap[i] = 0;
        end
        run_frame(4, 1'b0, 0, d, lat, got);
        checks++;
        if (!got || d !== 48'd100) begin
            failures++;
            $display("FAIL b2b_result got=%0d valid=%b want=100", d, got);
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL b2b_latency got=%0d want=3", lat);
        end
    endtask

    task automatic test_subtract;
        logic [47:0] d; int lat; bit got; logic [47:0] exp;
        opa[0] = 18'sd10; opb[0] = 18'sd10;
        opa[1] = 18'sd2;  opb[1] = 18'sd3;
        opa[2] = -18'sd1; opb[2] = 18'sd4;
        for (int i = 0; i < 3; i++) gap[i] = 0;
        exp = -48'd102;
        run_frame(3, 1'b1, 0, d, lat, got);
        checks++;
        if (!got || d !== exp) begin
            failures++;
            $display("FAIL sub_result got=%h valid=%b want=%h", d, got, exp);
        end
    endtask

    task automatic test_bubbles;
        bit sched [0:15];
        int pi;
        bit e_cea, e_cem, e_cep, e_rv;
        logic [7:0] e_opm;
        for (int i = 0; i < 16; i++) sched[i] = 1'b0;
        sched[2] = 1'b1; sched[5] = 1'b1; sched[8] = 1'b1;
        opa[0] = 18'sd4; opb[0] = 18'sd5;
        opa[1] = 18'sd6; opb[1] = 18'sd7;
        opa[2] = 18'sd1; opb[2] = 18'sd1;
        pi = 0;
        res_ready = 1'b0;
        start_frame(3, 1'b0);
        for (int t = 0; t < 11; t++) begin
            in_valid = sched[t+2];
            if (sched[t+2]) begin in_a = opa[pi]; in_b = opb[pi]; pi++; end
            #1;
            e_cea = sched[t+2]; e_cem = sched[t+1]; e_cep = sched[t];
            e_opm = e_cem ? ((t == 1) ? 8'h01 : 8'h09) : 8'h00;
            e_rv  = (t >= 9);
            checks++;
            if ({dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEOPMODE, dsp_CEP} !== {e_cea, e_cea, e_cem, e_cem, e_cep}) begin
                failures++;
                $display("FAIL gap_ce t=%0d got=%b want=%b", t,
                         {dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEOPMODE, dsp_CEP}, {e_cea, e_cea, e_cem, e_cem, e_cep});
            end
            checks++;
            if (dsp_opmode !== e_opm || res_valid !== e_rv) begin
                failures++;
                $display("FAIL gap_opm t=%0d opmode=%h want=%h res_valid=%b want=%b",
                         t, dsp_opmode, e_opm, res_valid, e_rv);
            end
            if (t == 9) begin
                checks++;
                if (res_data !== 48'd63) begin
                    failures++;
                    $display("FAIL gap_result got=%0d want=63", res_data);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_hold_backpressure;
        int xc; bit got; logic [47:0] exp;
        opa[0] = DATA_W'($urandom); opb[0] = DATA_W'($urandom); gap[0] = 0;
        opa[1] = DATA_W'($urandom); opb[1] = DATA_W'($urandom); gap[1] = 0;
        exp = ref_result(2, 1'b0);
        res_ready = 1'b0;
        got = 1'b0;
        start_frame(2, 1'b0);
        push_pairs(2, xc);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk); #1;
            if (res_valid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL hold_timeout res_valid=0 want=1");
        end
        for (int h = 0; h < 5; h++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp || dsp_CEP !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable h=%0d res_valid=%b data=%h want=%h cep=%b busy=%b",
                         h, res_valid, res_data, exp, dsp_CEP, busy);
            end
            @(negedge clk);
            start = (h == 1); frame_len = LEN_W'(7);
            #1;
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_handshake busy=%b res_valid=%b want=1", busy, res_valid);
        end
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_release busy=%b res_valid=%b want=0", busy, res_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_while_busy in_ready=%b busy=%b want=0", in_ready, busy);
        end
    endtask

    task automatic test_abort;
        int xc; int rstm_hi; int rstp_hi; int rv_hi;
        logic [47:0] d; int lat; bit got;
        for (int i = 0; i < 5; i++) begin
            opa[i] = DATA_W'(i+2); opb[i] = DATA_W'(i+3); gap[i] = 0;
        end
        res_ready = 1'b0;
        start_frame(5, 1'b0);
        push_pairs(2, xc);
        abort = 1'b1;
        #1;
        rstm_hi = dsp_RSTM; rstp_hi = dsp_RSTP; rv_hi = res_valid;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (dsp_RSTM !== 1'b1 || dsp_RSTP !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_next rstm=%b rstp=%b busy=%b in_ready=%b want=1,1,0,0",
                     dsp_RSTM, dsp_RSTP, busy, in_ready);
        end
        for (int t = 0; t < 8; t++) begin
            rstm_hi += dsp_RSTM; rstp_hi += dsp_RSTP; rv_hi += res_valid;
            @(negedge clk); #1;
        end
        checks++;
        if (rstm_hi != 1 || rstp_hi != 1 || rv_hi != 0) begin
            failures++;
            $display("FAIL abort_pulse rstm_cycles=%0d rstp_cycles=%0d res_valid_cycles=%0d want=1,1,0",
                     rstm_hi, rstp_hi, rv_hi);
        end
        opa[0] = 18'sd9; opb[0] = 18'sd9; gap[0] = 0;
        run_frame(1, 1'b0, 0, d, lat, got);
        checks++;
        if (!got || d !== 48'd81 || lat !== 3) begin
            failures++;
            $display("FAIL after_abort got=%0d lat=%0d valid=%b want=81 lat=3", d, lat, got);
        end
    endtask

    task automatic test_len_zero;
        int err_hi; int busy_hi;
        @(negedge clk);
        start = 1'b1; frame_len = '0;
        #1;
        err_hi = len_err; busy_hi = busy;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #1;
            err_hi += len_err; busy_hi += busy;
            @(negedge clk);
        end
        checks++;
        if (err_hi != 1 || busy_hi != 0) begin
            failures++;
            $display("FAIL len_zero len_err_cycles=%0d busy_cycles=%0d want=1,0", err_hi, busy_hi);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (dsp_RSTM !== 1'b0 || dsp_RSTP !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle rstm=%b rstp=%b busy=%b want=0", dsp_RSTM, dsp_RSTP, busy);
        end
    endtask

    task automatic test_max_len;
        logic [47:0] d; int lat; bit got; bit sub; logic [47:0] exp;
        int len;
        len = (1 << LEN_W) - 1;
        sub = 1'($urandom);
        for (int i = 0; i < len; i++) begin
            opa[i] = DATA_W'($urandom); opb[i] = DATA_W'($urandom); gap[i] = 0;
        end
        exp = ref_result(len, sub);
        run_frame(len, sub, 1, d, lat, got);
        checks++;
        if (!got || d !== exp || lat !== 3) begin
            failures++;
            $display("FAIL max_len got=%h lat=%0d valid=%b want=%h lat=3", d, lat, got, exp);
        end
    endtask

    task automatic test_random;
        logic [47:0] d; int lat; bit got; bit sub; logic [47:0] exp;
        int len;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 10);
            sub = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                opa[i] = DATA_W'($urandom); opb[i] = DATA_W'($urandom);
                gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            exp = ref_result(len, sub);
            run_frame(len, sub, $urandom_range(0, 3), d, lat, got);
            checks++;
            if (!got || d !== exp) begin
                failures++;
                $display("FAIL random_result frame=%0d len=%0d sub=%b got=%h want=%h", f, len, sub, d, exp);
            end
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL random_latency frame=%0d got=%0d want=3", f, lat);
            end
        end
    endtask

    task automatic test_rst_mid_run;
        start_frame(20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = DATA_W'($urandom); in_b = DATA_W'($urandom);
            @(negedge clk);
        end
        #1;
        checks++;
        if (dsp_CEM !== 1'b1 || in_ready !== 1'b1 || dsp_CEA !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst cem=%b in_ready=%b cea=%b want=1", dsp_CEM, in_ready, dsp_CEA);
        end
        #1;
        RST = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, res_valid, dsp_CEA, dsp_CEB, dsp_CEOPMODE, dsp_CEM, dsp_CEP,
             dsp_RSTM, dsp_RSTP} !== 10'b0 || dsp_opmode !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_run got=%b opmode=%h want=0", {in_ready, busy, res_valid, dsp_CEA,
                     dsp_CEB, dsp_CEOPMODE, dsp_CEM, dsp_CEP, dsp_RSTM, dsp_RSTP}, dsp_opmode);
        end
        @(negedge clk);
        in_valid = 1'b0;
        RST = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_rst busy=%b in_ready=%b want=0", busy, in_ready);
        end
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; frame_len = '0; frame_sub = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        test_reset;
        test_back_to_back;
        test_subtract;
        test_bubbles;
        test_hold_backpressure;
        test_abort;
        test_len_zero;
        test_max_len;
        test_random;
        test_rst_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1-style slice (the team's firstDSP) through multiply-accumulate frames of programmable length.
- Accepts operand pairs on a valid/ready stream, forwards them to the slice, and drives its opmode, clock-enable and reset pins in step with the slice pipeline.
- Returns the 48-bit accumulated P with a valid/ready handshake.
- The slice is built with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5"; this sequencer depends on exactly that configuration.

Parameters:
- LEN_W, 16, width of the frame-length field.
- DATA_W, 18, operand width; must equal the slice A/B width.

Ports:
- clk  in  1  clock, shared with the slice.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- frame_len  in  LEN_W  operand count for the frame; latched on start.
- frame_sub  in  1  1: P = -(sum); sets opmode[7]; latched on start.
- abort  in  1  synchronous frame cancel.
- busy  out  1  high in every state except IDLE.
- len_err  out  1  one-cycle pulse when start arrives with frame_len==0.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  DATA_W  multiplicand.
- in_b  in  DATA_W  multiplier.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_data  out  48  accumulated result.
- dsp_A  out  DATA_W  drives slice A; combinational copy of in_a.
- dsp_B  out  DATA_W  drives slice B; combinational copy of in_b.
- dsp_opmode  out  8  drives slice opmode.
- dsp_CEA, dsp_CEB, dsp_CEOPMODE, dsp_CEM, dsp_CEP  out  1 each  slice clock enables.
- dsp_RSTM, dsp_RSTP  out  1 each  slice synchronous resets.
- dsp_P  in  48  slice P output.

Behaviour:
- Reset values: all outputs 0 (in_ready, res_valid, busy, len_err, all CE/RST, dsp_opmode); FSM in IDLE; counters and shadow pipeline cleared.
- FSM states:
  - IDLE: waits for start. start with frame_len!=0 latches len and sub, then goes to RUN. start with frame_len==0 pulses len_err and stays in IDLE.
  - RUN: in_ready=1. A transfer is in_valid&&in_ready. Go to DRAIN after the len-th transfer.
  - DRAIN: in_ready=0. Wait until the retire count equals len.
  - HOLD: res_valid=1, res_data=dsp_P. dsp_CEP=0, so P is held. Return to IDLE on res_ready.
- Transfer at cycle k: in that cycle dsp_CEA=dsp_CEB=1, and a token carrying a first flag (set for transfer 1) enters a 2-stage shadow shift register.
- Cycle k+1: dsp_CEM=1, dsp_CEOPMODE=1, and dsp_opmode is driven from the token:
  - first token: {sub,7'b0000001}, i.e. X=M, Z=0.
  - other tokens: {sub,7'b0001001}, i.e. X=M, Z=P.
- Cycle k+2: dsp_CEP=1 and the retire count increments. The product of transfer k therefore lands in P at the end of cycle k+2, a fixed 3-cycle latency.
- Bubbles (in_valid=0 in RUN): CEs of the matching stages stay low, so slice registers hold. Back-to-back transfers every cycle are supported; throughput is 1 pair/cycle.
- Preadder, carry-in and C are unused: opmode[6:4]=0 always.
- When no token occupies a stage, dsp_opmode = 8'h00 and that stage's CE = 0.
- res_valid rises the cycle after the last retire. res_data is stable while res_valid && !res_ready.
- A start request while busy is ignored.
- abort in any non-IDLE state:
  - next cycle: state IDLE, shadow pipe flushed, counters cleared.
  - dsp_RSTM=dsp_RSTP=1 for exactly one cycle.
  - no res_valid is produced.
- abort in IDLE has no effect.
- Async RST mid-frame forces the reset values immediately. The slice is reset by the system RST separately.
- Count widths are LEN_W. frame_len = 2^LEN_W-1 must work with no wrap.

Decomposition:
- Shared package dsp_seq_pkg holds:
  - FSM state encoding (IDLE, RUN, DRAIN, HOLD).
  - opmode constants OPM_X_M=2'b01, OPM_Z_ZERO=2'b00, OPM_Z_P=2'b10, and OPMODE_SUB_BIT=7.
  - fixed slice latency constant DSP_MAC_LAT=3.
- One natural sub-module, dsp_seq_shadow_pipe: a 2-stage {valid, first} token shift register that generates the CEM/CEOPMODE/opmode stage and the CEP/retire stage.

Test Plan:
- Sequencer plus one slice instance, len=4, pairs (1,2),(3,4),(5,6),(7,8) on 4 back-to-back cycles -> res_valid 3 cycles after the 4th transfer, res_data=100.
- len=3, sub=1, pairs (10,10),(2,3),(-1,4) -> res_data = -(100+6-4) = -102 as 48-bit two's complement.
- len=3 with in_valid gaps of 2 idle cycles between pairs (4,5),(6,7),(1,1) -> res_data=63; CEA/CEM/CEP low during the gaps.
- Hold res_ready=0 for 5 cycles, then issue a start -> res_data stays constant, dsp_CEP=0, start ignored, busy=1; one cycle after res_ready=1, busy=0.
- abort 1 cycle after the 2nd transfer of a len=5 frame -> dsp_RSTM/dsp_RSTP pulse 1 cycle, no res_valid. A new len=1 frame with (9,9) then gives 81.
- start with frame_len=0 -> len_err 1 cycle, busy stays 0. Asserting RST mid-RUN -> in_ready and all CEs go 0 immediately.
